// File: rtl/fb_scanout_reader_if.sv
// AXI4 read-address/read-data channels and AXI4-Stream video channel of the
// framebuffer scanout engine; master = engine side, slave = memory/sink side.
interface fb_scanout_reader_if;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: credit-paced AXI4 burst reads into a pixel FIFO, emitted as AXI4-Stream video.
// Define FB_SCANOUT_CONT_EN for continuous (free-running) scanout from the latched base.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing read bursts as FIFO credits allow
// DRAIN | all bursts issued; waiting for the last pixel handshake
module fb_scanout_reader #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [31:0]          fb_base,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 rresp_err,
    fb_scanout_reader_if.master  bus
);
    localparam int NBURSTS = (H_RES * V_RES) / BURST_LEN;
    localparam int BW = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
`ifdef FB_SCANOUT_CONT_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [31:0]   base_q, araddr_q, tdata_q;
    logic [7:0]    arlen_q;
    logic [BW-1:0] burst_cnt;
    logic [CW-1:0] credits, cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          tvalid_q, start_acc, ar_hs, r_hs, s_hs, last_px, out_free, push, pop;
    wire           unused_rlast = bus.m_axi_rlast;

    assign busy      = (state != IDLE);
    assign start_acc = start && (state == IDLE);
    assign ar_hs     = bus.m_axi_arvalid && bus.m_axi_arready;
    assign r_hs      = bus.m_axi_rvalid && bus.m_axi_rready;
    assign s_hs      = tvalid_q && bus.m_axis_tready;
    assign last_px   = s_hs && (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    // Credits only grow while ISSUE waits, so arvalid cannot drop before arready.
    assign bus.m_axi_arvalid = (state == ISSUE) && (credits >= CW'(BURST_LEN));
    assign bus.m_axi_rready  = busy;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tuser  = tvalid_q && (x == '0) && (y == '0);
    assign bus.m_axis_tlast  = tvalid_q && (x == XW'(H_RES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (ar_hs && (burst_cnt == BW'(NBURSTS - 1))) state_nxt = DRAIN;
            DRAIN:   if (last_px) state_nxt = CONT ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            base_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            burst_cnt  <= '0;
            frame_done <= 1'b0;
            rresp_err  <= 1'b0;
            credits    <= CW'(FIFO_DEPTH);
        end else begin
            state      <= state_nxt;
            frame_done <= last_px;
            credits    <= credits + CW'(s_hs) - (ar_hs ? CW'(BURST_LEN) : CW'(0));
            if (start_acc) begin
                base_q    <= fb_base;
                araddr_q  <= fb_base;
                arlen_q   <= 8'(BURST_LEN - 1);
                burst_cnt <= '0;
                rresp_err <= 1'b0;
            end else begin
                if (ar_hs) begin
                    araddr_q  <= araddr_q + 32'(BURST_LEN * 4);
                    burst_cnt <= burst_cnt + 1'b1;
                end
                if (r_hs && (bus.m_axi_rresp != 2'b00)) rresp_err <= 1'b1;
                if (CONT && (state == DRAIN) && last_px) begin
                    araddr_q  <= base_q;
                    burst_cnt <= '0;
                end
            end
        end
    end

    // Output register refills every cycle it frees up; an empty FIFO lets R data bypass straight in.
    assign out_free = !tvalid_q || bus.m_axis_tready;
    assign pop      = out_free && (cnt != '0);
    assign push     = r_hs && !(out_free && (cnt == '0));

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= bus.m_axi_rdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (out_free) begin
                if (cnt != '0) begin
                    tdata_q  <= mem[rd_ptr];
                    tvalid_q <= 1'b1;
                end else if (r_hs) begin
                    tdata_q  <= bus.m_axi_rdata;
                    tvalid_q <= 1'b1;
                end else begin
                    tvalid_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            x <= '0;
            y <= '0;
        end else if (s_hs) begin
            if (x == XW'(H_RES - 1)) begin
                x <= '0;
                y <= (y == YW'(V_RES - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Framebuffer scanout engine: on a start pulse, reads one packed 32-bit-per-pixel frame from memory through an AXI4 read master and emits it as an AXI4-Stream video stream. Sits directly downstream of the pixel-writing AXI master, which renders into the framebuffer at `fb_base` (typically 0x0700_0000). Feeds the display output path.

## Interface
- `H_RES`, 640, active pixels per line.
- `V_RES`, 480, lines per frame.
- `BURST_LEN`, 16, beats per AXI read burst; power of two, 1..256.
- `FIFO_DEPTH`, 64, pixel FIFO entries; power of two, multiple of `BURST_LEN`, at least 2×`BURST_LEN`.
- `aclk`  in  1  sole clock; all logic on its rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts a frame when idle.
- `fb_base`  in  32  frame base byte address; sampled on an accepted `start`; must be aligned to `BURST_LEN`×4.
- `busy`  out  1  high from an accepted `start` until the last pixel handshakes.
- `frame_done`  out  1  one-cycle pulse on the cycle after the last pixel handshake.
- `rresp_err`  out  1  sticky; set on any `rresp` != OKAY; cleared by reset or an accepted `start`.
- `m_axi_araddr` out 32, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AXI4 read address channel.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI4 read data channel.
- `m_axis_tdata` out 32, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tuser` out 1 (start of frame), `m_axis_tlast` out 1 (end of line).

## Operation
- Constants: total beats = `H_RES`×`V_RES`, which must be a multiple of `BURST_LEN`. Bursts = total beats / `BURST_LEN`. `arlen` = `BURST_LEN`-1, `arsize` = 3'b010, `arburst` = INCR.
- Address FSM has three states:
  - IDLE: an accepted `start` latches `fb_base`, clears the burst count and moves to ISSUE. `start` is ignored while `busy`.
  - ISSUE: asserts `arvalid` only when free credits ≥ `BURST_LEN`. On the `arvalid`&`arready` cycle, reserves `BURST_LEN` credits, adds `BURST_LEN`×4 to `araddr`, and increments the burst count. After the final burst is accepted, moves to DRAIN.
  - DRAIN: waits for the last stream handshake, pulses `frame_done`, and returns to IDLE.
- Credits: a counter of unreserved FIFO entries, reset to `FIFO_DEPTH`. It decrements by `BURST_LEN` on an AR handshake and increments by 1 on each stream handshake. Both events in the same cycle apply net. It never goes below 0.
- `rready` is held 1 while `busy`; reservation guarantees FIFO room. R beats are written to the FIFO in arrival order. `rlast` is not checked.
- Stream side: x/y counters advance on each `tvalid`&`tready`.
  - `tuser` = 1 at x=0, y=0.
  - `tlast` = 1 at x=`H_RES`-1.
  - x wraps to 0 and increments y. y wraps at `V_RES`.
- AXIS rule: once `tvalid` is asserted, `tdata`/`tuser`/`tlast` hold stable until `tready`.
- `araddr` wraps modulo 2^32 with no error.
- Reset mid-frame: FSM returns to IDLE and the FIFO empties. Outstanding AXI bursts are abandoned; the memory slave must be reset in the same domain.

## Timing
- Reset values: `busy`, `frame_done`, `rresp_err`, `arvalid`, `rready`, `tvalid`, `tuser`, `tlast` = 0. `araddr`, `arlen`, `tdata` = 0.
- `start` accepted in cycle N gives `busy`=1 and `arvalid`=1 in cycle N+1.
- An R beat accepted in cycle M appears on `tvalid` in cycle M+1 at the earliest (registered FIFO output).
- FIFO sustains 1 beat/cycle in and 1 out simultaneously, including the full and empty boundaries.
- Final stream handshake in cycle K gives `frame_done`=1 and `busy`=0 in cycle K+1. A new `start` is accepted in cycle K+1.
- `rresp_err` is set in the cycle after the offending beat.

## Configuration
- `FB_SCANOUT_CONT_EN` defined: after `frame_done`, the engine restarts from the latched `fb_base` in the next cycle without `start`. `busy` stays high; `frame_done` still pulses once per frame. `start` while busy is ignored; reset is the only way to stop.
- Not defined: single-shot; returns to IDLE after each frame.

## Test plan
Bench parameters: `H_RES`=8, `V_RES`=2, `BURST_LEN`=4, `FIFO_DEPTH`=8, with a memory slave returning data = address.
- Start with `fb_base`=0x0700_0000 and `tready`=1 → four ARs at 0x0700_0000, +0x10, +0x20, +0x30, each with `arlen`=3. Stream is 0x0700_0000..0x0700_003C; `tuser` on beat 0; `tlast` on beats 7 and 15; `frame_done` one cycle after beat 15.
- Hold `tready`=0 → at most 2 bursts outstanding (credits=0) and `tvalid`/`tdata` stable. Release `tready` → the remaining ARs issue and no beat is lost.
- Slave returns `rresp`=SLVERR on beat 5 → `rresp_err`=1 from the next cycle and the frame still completes. A new `start` clears it.
- Pulse `start` again while `busy` → no extra AR and `fb_base` is not re-latched.
- Assert `areset` after the 2nd AR → all outputs at reset values next cycle. A fresh `start` produces a correct full frame.
- With `FB_SCANOUT_CONT_EN` → two consecutive frames, two `frame_done` pulses, and `tuser` at beats 0 and 16.
